// File: rtl/pid_pkg.sv
// pid_pkg: state encodings and magnitude helpers shared by the PID output path.
// The BRAKE state label exists only when PWM_BRAKE_EN is defined.
package pid_pkg;

  localparam logic [2:0] COAST = 3'd0;
  localparam logic [2:0] FWD   = 3'd1;
  localparam logic [2:0] REV   = 3'd2;
  localparam logic [2:0] DEAD  = 3'd3;
  localparam logic [2:0] BRAKE = 3'd4;

  typedef enum logic [2:0] {
    ST_COAST = COAST,
    ST_FWD   = FWD,
    ST_REV   = REV,
    ST_DEAD  = DEAD
`ifdef PWM_BRAKE_EN
    , ST_BRAKE = BRAKE
`endif
  } pwm_state_t;

  function automatic int mag_w(input int ow);
    return ow - 1;
  endfunction

  // |v| clipped to 2^n-1, so the most negative word maps to full scale
  function automatic logic [31:0] sat_abs(
    input logic signed [31:0] v,
    input int                 n
  );
    logic signed [31:0] lim;
    lim = 32'sd1 <<< n;
    if (v < 0) begin
      if (-v >= lim) return 32'(lim - 1);
      return 32'(-v);
    end
    return 32'(v);
  endfunction

endpackage

// File: rtl/pwm_dead_timer_v.sv
// pwm_dead_timer_v: loadable down-counter that flags completion at zero.
// It stops at zero so a stale load can never wrap into a long dead band.
module pwm_dead_timer_v #(
  parameter int w = 11
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [w-1:0] val,
  input  logic         dec,
  output logic         done
);

  logic [w-1:0] dtc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dtc <= '0;
    end else if (load) begin
      dtc <= val;
    end else if (dec && dtc != '0) begin
      dtc <= dtc - 1'b1;
    end
  end

  assign done = (dtc == '0);

endmodule

// File: rtl/pwm_hbridge_v.sv
// pwm_hbridge_v: edge-aligned H-bridge PWM with per-period latch and dead time.
// Define PWM_BRAKE_EN to turn zero magnitude into a both-legs-high brake.
module pwm_hbridge_v
  import pid_pkg::*;
#(
  parameter int ow = 12,
  parameter int dt = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic signed [ow-1:0] m_k,
  output logic                 pwm_a,
  output logic                 pwm_b,
  output logic                 period_strobe,
  output logic                 dir
);

  localparam int N = mag_w(ow);
  localparam logic [N-1:0] DT_LOAD = N'(dt - 1);

`ifdef PWM_BRAKE_EN
  localparam pwm_state_t IDLE = ST_BRAKE;
`else
  localparam pwm_state_t IDLE = ST_COAST;
`endif

  logic [N-1:0]       cnt;
  logic [N-1:0]       duty_q;
  logic [N-1:0]       mag;
  logic               dir_q;
  logic               sign;
  logic               latch;
  logic               zero;
  logic               flip;
  logic               hit;
  logic               brk;
  logic               done;
  logic signed [31:0] mk_ext;
  pwm_state_t         state;

  assign mk_ext = 32'(m_k);
  assign mag    = N'(sat_abs(mk_ext, N));
  assign sign   = m_k[ow-1];
  assign latch  = (cnt == '1);
  assign zero   = (mag == '0);
  assign hit    = (cnt < duty_q);

  // reversal only counts when a leg is actually being driven
  assign flip = !zero &&
                ((state == ST_FWD && sign) ||
                 (state == ST_REV && !sign));

`ifdef PWM_BRAKE_EN
  assign brk = (state == ST_BRAKE);
`else
  assign brk = 1'b0;
`endif

  pwm_dead_timer_v #(
    .w(N)
  ) u_dead (
    .clk  (clk),
    .reset(reset),
    .load (latch && flip),
    .val  (DT_LOAD),
    .dec  (state == ST_DEAD),
    .done (done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt           <= '0;
      duty_q        <= '0;
      dir_q         <= 1'b0;
      state         <= ST_COAST;
      pwm_a         <= 1'b0;
      pwm_b         <= 1'b0;
      period_strobe <= 1'b0;
      dir           <= 1'b0;
    end else begin
      cnt           <= cnt + 1'b1;
      period_strobe <= latch;
      pwm_a <= en && ((state == ST_FWD && hit) || brk);
      pwm_b <= en && ((state == ST_REV && hit) || brk);
      if (latch) begin
        duty_q <= mag;
        dir_q  <= sign;
        unique case (1'b1)
          zero: state <= IDLE;
          flip: state <= ST_DEAD;
          default: begin
            state <= sign ? ST_REV : ST_FWD;
            dir   <= sign;
          end
        endcase
      end else if (state == ST_DEAD && done) begin
        state <= dir_q ? ST_REV : ST_FWD;
        dir   <= dir_q;
      end
    end
  end

endmodule

// File: doc/pwm_hbridge_v.md
Name: pwm_hbridge_v

Overview:
- Downstream stage of the PID controller: consumes the signed motor-power word `m_k_out` (sign plus magnitude) and drives the two H-bridge inputs with edge-aligned PWM.
- Duty and direction are latched once per PWM period.
- Dead time is inserted on every direction reversal.
- A per-period strobe is exported so software or the PID sequencer can pace updates.

Parameters:
- ow, 12: width of the signed input word; magnitude width n = ow-1; period = 2^(ow-1) clocks.
- dt, 16: dead-time length in clocks; legal range 1 <= dt < 2^(ow-1).

Ports:
- clk  in  1  single clock
- reset  in  1  asynchronous, active-high reset
- en  in  1  1 = drive outputs; 0 = force coast (counter keeps running)
- m_k  in  ow  signed motor power (two's complement)
- pwm_a  out  1  forward leg; registered
- pwm_b  out  1  reverse leg; registered
- period_strobe  out  1  one-clock pulse on each latch edge
- dir  out  1  currently driven direction: 0 = forward, 1 = reverse

Behaviour:
- Reset values: cnt=0, duty_q=0, dir_q=0, state=COAST, dtc=0, pwm_a=0, pwm_b=0, period_strobe=0, dir=0.
- Counter: cnt is n bits and free-runs 0..2^n-1, then wraps to 0.
- Latch edge: the clock edge at which cnt==2^n-1.
  - duty_q <= sat_abs(m_k); dir_q <= m_k[ow-1].
  - period_strobe=1 for the following cycle only.
- sat_abs: |m_k|, with the most negative value -2^(ow-1) saturated to 2^n-1.
- Samples of m_k at any other edge are ignored; mid-period changes have no effect until the next latch.
- FSM states COAST, FWD, REV, DEAD. Transitions are evaluated at the latch edge using the new duty/sign:
  - mag==0 -> COAST.
  - mag!=0 from COAST -> FWD or REV directly (no dead time).
  - mag!=0, same direction as current -> stay.
  - mag!=0, opposite direction from FWD/REV -> DEAD; dtc loaded with dt-1; target direction stored.
  - DEAD: dtc decrements every clock; at dtc==0 the next edge enters the target direction.
  - dt < period guarantees DEAD ends before the next latch.
- Outputs, registered, one clock after the cnt value that produced them:
  - pwm_a = en & (state==FWD) & (cnt < duty_q)
  - pwm_b = en & (state==REV) & (cnt < duty_q)
- Output invariants:
  - Both outputs are low in COAST and DEAD (without the brake feature).
  - pwm_a and pwm_b are never high together.
- dir output: follows the FWD/REV state; holds its last value through COAST and DEAD.
- Duty boundaries:
  - duty 0 -> output always low.
  - duty 2^n-1 -> high 2^n-1 of 2^n clocks; 100% duty is never reached.
- en deassert: outputs go low on the next edge; FSM, counter and latching continue unaffected.
- Reset asserted mid-period: every register returns to its reset value immediately; the first latch occurs 2^n clocks after reset release.

Optional Feature:
- Macro: PWM_BRAKE_EN.
- When defined:
  - A zero magnitude selects a BRAKE state instead of COAST; both outputs are held high (slow-decay brake), ANDed with en.
  - BRAKE -> FWD/REV and FWD/REV -> BRAKE transitions take no dead time.
  - Reversal still passes through DEAD with both outputs low.
- When undefined: BRAKE state and logic are absent; behaviour is exactly as above.

Decomposition:
- Shared package pid_pkg:
  - FSM state encoding localparams (COAST, FWD, REV, DEAD, BRAKE).
  - n = ow-1 derivation.
  - sat_abs function, reusable by the PID output path.
- One natural sub-module: pwm_dead_timer_v (load, decrement, done flag), instantiated once.

Test Plan:
- Reset release, m_k=512 -> first period_strobe at clock 2048; next period pwm_a high exactly 512 clocks, pwm_b always 0, dir=0.
- m_k=-300 steady -> pwm_b high 300 clocks per period, pwm_a 0, dir=1.
- FWD at 512, m_k switched to -512 -> at latch, 16 clocks with both outputs low; pwm_b then resumes for the remainder of the period, under the cnt<512 compare.
- m_k=-2048 -> duty saturates to 2047; pwm_b low exactly 1 clock per period.
- m_k changed 100->900 mid-period -> current period still 100 clocks high; 900 from the next period.
- Reset pulse mid-high, plus en=0 mid-period:
  - Reset -> pwm_a drops asynchronously and stays 0 until 2048 clocks after release.
  - en=0 -> outputs 0 on the next edge.
  - m_k=0 with PWM_BRAKE_EN defined -> both outputs 1.
